// File: rtl/snvg_run_ctrl.sv
// Run controller for a Petri-net simulation engine: load, step/wait loop, deadlock/limit/halt termination.
// Optional response watchdog (done_code 4) is built only when SNVG_WDOG_EN is defined.
module snvg_run_ctrl #(
    parameter int STEP_W   = 16,
    parameter int WDOG_CYC = 15
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              halt,
    input  logic [STEP_W-1:0] max_steps,
    output logic              eng_load,
    output logic              eng_step,
    input  logic              eng_valid,
    input  logic [4:0]        eng_tf,
    output logic              busy,
    output logic              done,
    output logic [2:0]        done_code,
    output logic [STEP_W-1:0] step_cnt,
    output logic [4:0]        last_tf
);

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_DEADLOCK = 3'd1;
    localparam logic [2:0] CODE_LIMIT    = 3'd2;
    localparam logic [2:0] CODE_HALT     = 3'd3;
`ifdef SNVG_WDOG_EN
    localparam logic [2:0] CODE_TIMEOUT  = 3'd4;
    localparam int         WDOG_W        = $clog2(WDOG_CYC + 1);
`endif

    if (STEP_W < 1 || WDOG_CYC < 1) begin : g_param_check
        $error("snvg_run_ctrl: STEP_W and WDOG_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] limit_q, limit_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [4:0]        last_q, last_d;
    logic [2:0]        code_q, code_d;
    logic              eng_load_q, eng_load_d;
    logic              eng_step_q, eng_step_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [STEP_W-1:0] cnt_inc;
    logic [STEP_W-1:0] cnt_end;
`ifdef SNVG_WDOG_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

    // A zero limit means "unlimited", which still ends when the counter saturates.
    assign cnt_inc = cnt_q + 1'b1;
    assign cnt_end = (limit_q == '0) ? '1 : limit_q;

    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        code_d  = code_q;
`ifdef SNVG_WDOG_EN
        wdog_d  = wdog_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    limit_d = max_steps;
                    cnt_d   = '0;
                    last_d  = '0;
                    code_d  = CODE_NONE;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: state_d = S_STEP;
            S_STEP: begin
                state_d = S_WAIT;
`ifdef SNVG_WDOG_EN
                wdog_d  = '0;
`endif
            end
            S_WAIT: begin
                // Deadlock beats limit beats halt; a non-deadlock firing is always counted.
                if (eng_valid) begin
                    if (eng_tf == 5'd0) begin
                        code_d  = CODE_DEADLOCK;
                        state_d = S_DONE;
                    end else begin
                        cnt_d  = cnt_inc;
                        last_d = eng_tf;
                        if (cnt_inc == cnt_end) begin
                            code_d  = CODE_LIMIT;
                            state_d = S_DONE;
                        end else if (halt) begin
                            code_d  = CODE_HALT;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_STEP;
                        end
                    end
                end
`ifdef SNVG_WDOG_EN
                else if (wdog_q == WDOG_W'(WDOG_CYC - 1)) begin
                    code_d  = CODE_TIMEOUT;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes and status are registered, so derive them from the next state.
        eng_load_d = (state_d == S_LOAD);
        eng_step_d = (state_d == S_STEP);
        busy_d     = (state_d == S_LOAD) || (state_d == S_STEP) || (state_d == S_WAIT);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            limit_q    <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            code_q     <= CODE_NONE;
            eng_load_q <= 1'b0;
            eng_step_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SNVG_WDOG_EN
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            code_q     <= code_d;
            eng_load_q <= eng_load_d;
            eng_step_q <= eng_step_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef SNVG_WDOG_EN
            wdog_q     <= wdog_d;
`endif
        end
    end

    assign eng_load  = eng_load_q;
    assign eng_step  = eng_step_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_code = code_q;
    assign step_cnt  = cnt_q;
    assign last_tf   = last_q;

endmodule

// File: doc/snvg_run_ctrl.md
SNVG_RUN_CTRL -- requirements
Module: snvg_run_ctrl

Interface
REQ-001 SHALL have parameter STEP_W, default 16, width of the step limit and step counter.
REQ-002 SHALL have parameter WDOG_CYC, default 15, maximum wait in cycles for an engine response (used only with SNVG_WDOG_EN).
REQ-003 sys_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 sys_rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle run request; honoured only in IDLE.
REQ-006 halt  in  1  stop request; sampled only in WAIT.
REQ-007 max_steps  in  STEP_W  step limit, latched on start; 0 = unlimited.
REQ-008 eng_load  out  1  one-cycle strobe that reloads the net's initial marking.
REQ-009 eng_step  out  1  one-cycle strobe that evaluates and fires one transition.
REQ-010 eng_valid  in  1  engine result valid; one cycle per eng_step.
REQ-011 eng_tf  in  5  index of the fired transition (1..31); 0 = none enabled.
REQ-012 busy  out  1  high from LOAD through WAIT.
REQ-013 done  out  1  one-cycle pulse on entry to DONE.
REQ-014 done_code  out  3  0 running/none, 1 deadlock, 2 limit, 3 halt, 4 timeout.
REQ-015 step_cnt  out  STEP_W  number of firings in the current or last run.
REQ-016 last_tf  out  5  eng_tf of the most recent valid firing.

Function
REQ-017 SHALL implement the FSM IDLE -> LOAD -> STEP -> WAIT -> (STEP | DONE) -> IDLE.
REQ-018 IDLE: on start, latch max_steps, clear step_cnt, last_tf and done_code, and go to LOAD.
REQ-019 LOAD: assert eng_load for exactly one cycle, then go to STEP.
REQ-020 STEP: assert eng_step for exactly one cycle, then go to WAIT.
REQ-021 WAIT with eng_valid and eng_tf==0: go to DONE with code 1; step_cnt is not incremented.
REQ-022 WAIT with eng_valid and eng_tf!=0: increment step_cnt and load last_tf from eng_tf.
REQ-023 After the increment in REQ-022: if the new step_cnt equals the latched limit (limit != 0), go to DONE with code 2.
REQ-024 Otherwise, if halt is high in the same cycle, go to DONE with code 3.
REQ-025 Otherwise return to STEP, so the minimum period is 2 cycles per firing.
REQ-026 Priority on a simultaneous valid response and halt: deadlock > limit > halt; the firing is still counted.
REQ-027 Unlimited run (limit 0): step_cnt saturates at all-ones, which ends the run with code 2.
REQ-028 DONE: pulse done for one cycle, deassert busy, and go to IDLE; step_cnt, last_tf and done_code hold until the next start.
REQ-029 start outside IDLE is ignored; halt outside WAIT is ignored; eng_valid outside WAIT is ignored.
REQ-030 eng_load and eng_step are never high together and are never high outside LOAD and STEP respectively.

Reset
REQ-031 sys_rst asynchronously forces IDLE.
REQ-032 sys_rst forces eng_load=0, eng_step=0, busy=0, done=0, done_code=0, step_cnt=0 and last_tf=0.
REQ-033 Reset asserted mid-run aborts the run immediately with no done pulse; the next start reloads the marking via LOAD.

Configuration
REQ-034 Macro SNVG_WDOG_EN defined: a counter runs in WAIT.
REQ-035 With SNVG_WDOG_EN, the counter is cleared on entry to WAIT; if WDOG_CYC cycles elapse without eng_valid, go to DONE with code 4.
REQ-036 With SNVG_WDOG_EN, an eng_valid arriving on the same cycle as expiry takes precedence over timeout.
REQ-037 Macro SNVG_WDOG_EN undefined: WAIT waits indefinitely, code 4 is never produced, and no watchdog logic is present.

Verification
REQ-038 Engine returns tf=3,5,0 with max_steps=0 -> 3 eng_step pulses, step_cnt=2, last_tf=5, done_code=1, one done pulse.
REQ-039 max_steps=4 and engine always returns tf=1 -> exactly 4 eng_step pulses, step_cnt=4, done_code=2, eng_load pulsed once.
REQ-040 halt held high from the 2nd WAIT onward, engine returns tf=2 -> step_cnt=2, done_code=3.
REQ-041 max_steps=1, tf=7 returned with halt=1 in the same cycle -> done_code=2, step_cnt=1.
REQ-042 sys_rst pulsed during WAIT of step 3 -> all outputs zero and no done pulse; a restart shows eng_load first and step_cnt counting from 1.
REQ-043 With SNVG_WDOG_EN and WDOG_CYC=15, engine silent -> done 15 cycles after the WAIT entry with code 4; without the macro, busy stays high for 100 cycles.
